// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory arbiter grant scheduler.
// Latency: none (types, constants and a combinational helper only).
// Backpressure: not applicable.
package mem_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } sched_state_t;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_WRR   = 1'b1;

    // Upper bound on the client count; onehot_to_id works on this width.
    localparam int MAX_CLIENTS = 8;

    // Binary index of the set bit in a one-hot vector (0 when empty).
    function automatic logic [2:0] onehot_to_id(input logic [MAX_CLIENTS-1:0] oh);
        logic [2:0] id;
        id = '0;
        for (int i = 0; i < MAX_CLIENTS; i++) begin
            if (oh[i]) begin
                id = 3'(i);
            end
        end
        return id;
    endfunction

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Round-robin picker: first eligible client at or above ptr_i, wrapping to 0.
// Latency: purely combinational.
// Backpressure: none; found_o is low when no client is eligible.
// Ports: eligible_i (request mask), ptr_i (search start), win_o (one-hot), found_o.
module mem_arb_rr_pick #(
    parameter int CLIENTS  = 3,
    parameter int ID_WIDTH = 2
) (
    input  logic [CLIENTS-1:0]  eligible_i,
    input  logic [ID_WIDTH-1:0] ptr_i,
    output logic [CLIENTS-1:0]  win_o,
    output logic                found_o
);

    logic [CLIENTS-1:0] rot;
    logic [CLIENTS-1:0] rot_oh;

    always_comb begin
        // Rotate right by ptr so the search start lands on bit 0.
        rot    = CLIENTS'({eligible_i, eligible_i} >> ptr_i);
        // Isolate the lowest set bit.
        rot_oh = rot & (~rot + CLIENTS'(1));
        // Rotate the one-hot result back into client index space.
        win_o   = CLIENTS'(({rot_oh, rot_oh} << ptr_i) >> CLIENTS);
        found_o = |eligible_i;
    end

endmodule

// File: rtl/mem_arb_wrr_sched.sv
// Grant scheduler for the shared memory port: fixed priority or credit-based WRR.
// Latency: grant registered one cycle after the arbitration (IDLE) cycle.
// Backpressure: grant is held until m_ack; enable=0 blocks new grants only.
// Ports: clk, rst (async active-low), enable, mode, weights, req, m_ack -> gnt, gnt_valid, gnt_id.
module mem_arb_wrr_sched
    import mem_arb_pkg::*;
#(
    parameter  int CLIENTS      = 3,
    parameter  int WEIGHT_WIDTH = 4,
    localparam int ID_WIDTH     = (CLIENTS > 1) ? $clog2(CLIENTS) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            enable,
    input  logic                            mode,
    input  logic [CLIENTS*WEIGHT_WIDTH-1:0] weights,
    input  logic [CLIENTS-1:0]              req,
    input  logic                            m_ack,
    output logic [CLIENTS-1:0]              gnt,
    output logic                            gnt_valid,
    output logic [ID_WIDTH-1:0]             gnt_id
);

    sched_state_t              state_q, state_d;
    logic [CLIENTS-1:0]        gnt_q, gnt_d;
    logic [ID_WIDTH-1:0]       gnt_id_q, gnt_id_d;
    logic [ID_WIDTH-1:0]       ptr_q, ptr_d;
    logic [WEIGHT_WIDTH-1:0]   credit_q [CLIENTS];
    logic [WEIGHT_WIDTH-1:0]   credit_d [CLIENTS];
    logic [WEIGHT_WIDTH-1:0]   credit_src [CLIENTS];

    logic                      reload;
    logic                      last_credit;
    logic [CLIENTS-1:0]        elig_wrr;
    logic [CLIENTS-1:0]        pick_elig;
    logic [ID_WIDTH-1:0]       pick_ptr;
    logic [CLIENTS-1:0]        win;
    logic                      found;
    logic [ID_WIDTH-1:0]       win_id;

    // Credit view for this arbitration cycle: if no requester has credit left,
    // every counter reloads to max(weight,1) and the pick uses those values.
    always_comb begin
        reload     = 1'b1;
        elig_wrr   = '0;
        credit_src = credit_q;
        for (int i = 0; i < CLIENTS; i++) begin
            if (req[i] && (credit_q[i] != '0)) begin
                reload = 1'b0;
            end
        end
        for (int i = 0; i < CLIENTS; i++) begin
            if (reload) begin
                credit_src[i] = (weights[i*WEIGHT_WIDTH +: WEIGHT_WIDTH] == '0)
                              ? WEIGHT_WIDTH'(1)
                              : weights[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
            end
            elig_wrr[i] = req[i] && (credit_src[i] != '0);
        end
    end

    // Fixed priority reuses the picker with the pointer pinned at 0.
    assign pick_elig = (mode == MODE_WRR) ? elig_wrr : req;
    assign pick_ptr  = (mode == MODE_WRR) ? ptr_q : '0;

    mem_arb_rr_pick #(
        .CLIENTS  (CLIENTS),
        .ID_WIDTH (ID_WIDTH)
    ) u_pick (
        .eligible_i (pick_elig),
        .ptr_i      (pick_ptr),
        .win_o      (win),
        .found_o    (found)
    );

    assign win_id = ID_WIDTH'(onehot_to_id(MAX_CLIENTS'(win)));

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        ptr_d       = ptr_q;
        credit_d    = credit_q;
        last_credit = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable && found) begin
                    state_d  = BUSY;
                    gnt_d    = win;
                    gnt_id_d = win_id;
                    if (mode == MODE_WRR) begin
                        for (int i = 0; i < CLIENTS; i++) begin
                            credit_d[i] = credit_src[i];
                            if (win[i]) begin
                                credit_d[i] = credit_src[i] - WEIGHT_WIDTH'(1);
                                if (credit_src[i] == WEIGHT_WIDTH'(1)) begin
                                    last_credit = 1'b1;
                                end
                            end
                        end
                        // Stay on the winner while it still has credit.
                        if (last_credit) begin
                            ptr_d = (win_id == ID_WIDTH'(CLIENTS - 1))
                                  ? '0 : win_id + ID_WIDTH'(1);
                        end else begin
                            ptr_d = win_id;
                        end
                    end
                end
            end
            BUSY: begin
                if (m_ack) begin
                    state_d  = IDLE;
                    gnt_d    = '0;
                    gnt_id_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            gnt_id_q <= '0;
            ptr_q    <= '0;
            for (int i = 0; i < CLIENTS; i++) begin
                credit_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            gnt_id_q <= gnt_id_d;
            ptr_q    <= ptr_d;
            credit_q <= credit_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = |gnt_q;
    assign gnt_id    = gnt_id_q;

endmodule

// File: tb/tb_mem_arb_wrr_sched.sv
module tb_mem_arb_wrr_sched;

    localparam int C  = 3;
    localparam int WW = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            enable = 1'b0;
    logic            mode = 1'b0;
    logic [C*WW-1:0] weights = '0;
    logic [C-1:0]    req = '0;
    logic            m_ack = 1'b0;
    logic [C-1:0]    gnt;
    logic            gnt_valid;
    logic [1:0]      gnt_id;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state: remaining credits and round-robin pointer.
    int m_cred[C];
    int m_ptr;

    int exp_wrr[12] = '{0, 0, 0, 1, 2, 2, 0, 0, 0, 1, 2, 2};
    int exp_w0[4]   = '{0, 2, 0, 2};

    mem_arb_wrr_sched #(.CLIENTS(C), .WEIGHT_WIDTH(WW)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .mode      (mode),
        .weights   (weights),
        .req       (req),
        .m_ack     (m_ack),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int wt(input int i);
        return int'(weights[i*WW +: WW]);
    endfunction

    task automatic set_w(input int w0, input int w1, input int w2);
        weights = {4'(w2), 4'(w1), 4'(w0)};
    endtask

    task automatic model_reset();
        for (int i = 0; i < C; i++) m_cred[i] = 0;
        m_ptr = 0;
    endtask

    // Arbitration per the scheduling rules; w = -1 when nothing is granted.
    task automatic model_arb(input logic [C-1:0] r, input logic m, output int w);
        bit any;
        w = -1;
        if (!enable || r == '0) return;
        if (!m) begin
            for (int i = 0; i < C; i++) begin
                if (r[i]) begin
                    w = i;
                    break;
                end
            end
            return;
        end
        any = 0;
        for (int i = 0; i < C; i++) if (r[i] && m_cred[i] > 0) any = 1;
        if (!any) begin
            for (int i = 0; i < C; i++) m_cred[i] = (wt(i) == 0) ? 1 : wt(i);
        end
        for (int k = 0; k < C; k++) begin
            int i;
            i = (m_ptr + k) % C;
            if (r[i] && m_cred[i] > 0) begin
                w = i;
                break;
            end
        end
        if (w >= 0) begin
            m_cred[w] = m_cred[w] - 1;
            m_ptr = (m_cred[w] > 0) ? w : (w + 1) % C;
        end
    endtask

    // One arbitration from IDLE, grant held for 'hold' cycles, then acked.
    // disturb changes req/mode while busy; ack_idle pulses m_ack in the IDLE cycle.
    task automatic txn(input logic [C-1:0] r, input logic m, input int hold,
                       input logic ack_idle, input logic disturb, output int got);
        int w;
        req   = r;
        mode  = m;
        m_ack = ack_idle;
        model_arb(r, m, w);
        step();
        m_ack = 1'b0;
        got = gnt_valid ? int'(gnt_id) : -1;
        if (w < 0) begin
            check("no_grant_gnt", gnt, 0);
            check("no_grant_valid", gnt_valid, 0);
            return;
        end
        check("grant_gnt", gnt, 3'b001 << w);
        check("grant_id", gnt_id, w);
        check("grant_valid", gnt_valid, 1);
        if (disturb) begin
            mode = ~m;
            req  = ~r;
        end
        for (int k = 0; k < hold; k++) begin
            step();
            check("hold_gnt", gnt, 3'b001 << w);
            check("hold_id", gnt_id, w);
        end
        m_ack = 1'b1;
        step();
        m_ack = 1'b0;
        check("ack_clear_gnt", gnt, 0);
        check("ack_clear_valid", gnt_valid, 0);
    endtask

    initial begin
        int got;
        int w;
        model_reset();

        // Reset holds outputs at zero even with requests present.
        rst = 1'b0; enable = 1'b1; mode = 1'b0; req = 3'b111;
        step();
        step();
        check("rst_gnt", gnt, 0);
        check("rst_valid", gnt_valid, 0);
        check("rst_id", gnt_id, 0);
        rst = 1'b1;
        step();
        check("post_rst_gnt", gnt, 3'b001);
        m_ack = 1'b1;
        step();
        m_ack = 1'b0;
        req = 3'b000;
        check("post_rst_ack", gnt, 0);

        // Latency: req at t -> gnt at t+1; ack at t+4 -> clear t+5 -> regrant t+6.
        step();
        check("idle_before_lat", gnt, 0);
        req = 3'b001;
        step();
        check("lat_t1", gnt, 3'b001);
        step();
        step();
        step();
        check("lat_t4_held", gnt, 3'b001);
        m_ack = 1'b1;
        step();
        m_ack = 1'b0;
        check("lat_t5_clear", gnt, 0);
        step();
        check("lat_t6_regrant", gnt, 3'b001);
        m_ack = 1'b1;
        step();
        m_ack = 1'b0;
        req = 3'b000;

        // m_ack in IDLE with no request does nothing.
        m_ack = 1'b1;
        step();
        m_ack = 1'b0;
        check("ack_idle_gnt", gnt, 0);

        // Fixed priority.
        txn(3'b110, 1'b0, 1, 1'b0, 1'b0, got);
        check("fixed_110", got, 1);
        txn(3'b100, 1'b0, 1, 1'b0, 1'b0, got);
        check("fixed_100", got, 2);

        // WRR with weights {2:2, 1:1, 0:3}.
        set_w(3, 1, 2);
        for (int k = 0; k < 12; k++) begin
            txn(3'b111, 1'b1, 2, 1'b0, 1'b0, got);
            check("wrr_seq", got, exp_wrr[k]);
        end

        // Zero weights act as one and force a reload every round.
        set_w(0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            txn(3'b101, 1'b1, 2, 1'b0, 1'b0, got);
            check("w0_seq", got, exp_w0[k]);
        end

        // Disable while busy: grant completes, nothing new until re-enabled.
        req = 3'b111; mode = 1'b0; enable = 1'b1;
        step();
        check("dis_grant", gnt, 3'b001);
        enable = 1'b0;
        step();
        check("dis_held", gnt, 3'b001);
        m_ack = 1'b1;
        step();
        m_ack = 1'b0;
        check("dis_clear", gnt, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            check("dis_no_grant", gnt, 0);
        end
        enable = 1'b1;
        step();
        check("reenable_grant", gnt, 3'b001);
        m_ack = 1'b1;
        step();
        m_ack = 1'b0;
        check("reenable_clear", gnt, 0);

        // Reset mid-transaction clears outputs immediately and wipes credits.
        set_w(3, 1, 2);
        txn(3'b111, 1'b1, 0, 1'b0, 1'b0, got);
        txn(3'b010, 1'b1, 0, 1'b0, 1'b0, got);
        req = 3'b111; mode = 1'b1;
        model_arb(3'b111, 1'b1, w);
        step();
        check("busy_before_rst", gnt_id, w);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_gnt", gnt, 0);
        check("async_rst_valid", gnt_valid, 0);
        check("async_rst_id", gnt_id, 0);
        model_reset();
        step();
        check("rst_hold_gnt", gnt, 0);
        rst = 1'b1;
        txn(3'b111, 1'b1, 1, 1'b0, 1'b0, got);
        check("post_rst_wrr", got, 0);
        txn(3'b010, 1'b1, 1, 1'b0, 1'b0, got);

        // Randomized traffic against the reference model.
        for (int k = 0; k < 80; k++) begin
            logic [C-1:0] r;
            logic m;
            r = C'($urandom_range(0, 7));
            m = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 5) == 0) begin
                set_w($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
            end
            enable = ($urandom_range(0, 7) != 0);
            txn(r, m, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), got);
        end
        enable = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arb_wrr_sched.md
Name: mem_arb_wrr_sched

Overview:
Grant scheduler for the shared memory SDT port of the memory arbiter. It takes one request bit per client and issues a single one-hot grant, using either fixed priority or credit-based weighted round-robin (WRR). It holds the grant until the memory acknowledges, then re-arbitrates. The arbiter muxes client SDT signals onto m_* using gnt and gnt_id; mode and weights come from the APB configuration registers.

Parameters:
CLIENTS, 3, number of requesting SDT clients (2..8)
WEIGHT_WIDTH, 4, bits per client weight and per credit counter
ID_WIDTH, $clog2(CLIENTS), width of gnt_id (derived, not overridable)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous reset, active-low (0 = reset)
enable  in  1  1 = new grants allowed; 0 = finish current transaction, no new grant
mode  in  1  0 = fixed priority (lowest index wins); 1 = WRR
weights  in  CLIENTS*WEIGHT_WIDTH  client i weight at [i*WEIGHT_WIDTH +: WEIGHT_WIDTH]
req  in  CLIENTS  client i has a pending rd or wr (c_rd | c_wr)
m_ack  in  1  memory acknowledge, ends the granted transaction
gnt  out  CLIENTS  one-hot grant, registered
gnt_valid  out  1  OR of gnt
gnt_id  out  ID_WIDTH  binary index of the granted client, valid while gnt_valid

Behaviour:
- Reset (rst=0, asynchronous): gnt=0, gnt_valid=0, gnt_id=0, all credits=0, rr pointer=0, state=IDLE.
- FSM states: IDLE, BUSY.
- IDLE:
  - If enable=1 and req!=0: compute winner combinationally; on the next edge gnt/gnt_id load the winner and the FSM moves to BUSY.
  - Otherwise stay in IDLE with gnt=0.
- BUSY:
  - gnt held constant; req and mode changes are ignored.
  - On m_ack=1: next edge clears gnt and returns to IDLE.
- Timing: grant latency is 1 cycle from req in IDLE. There is always at least one idle cycle (gnt=0) between consecutive grants. Earliest regrant is 2 cycles after the m_ack cycle.
- m_ack while in IDLE: ignored.
- req deasserted during BUSY: protocol violation; grant is still held until m_ack.
- Fixed priority (mode=0): winner is the lowest set index of req. Credits and pointer are unchanged.
- WRR (mode=1):
  - Effective weight is max(weight, 1), so weight 0 behaves as 1.
  - Eligible client: req=1 and credit>0.
  - If no requesting client is eligible, all credits reload to their effective weights in the arbitration cycle, and the winner is picked from the reloaded values in that same cycle.
  - Winner is the first eligible index searching upward from the pointer, wrapping from CLIENTS-1 to 0.
  - On grant: winner credit decrements by 1. Pointer stays on the winner if the new credit is >0; otherwise pointer = (winner+1) mod CLIENTS.
- mode and weights are sampled only in the arbitration cycle. A weight change takes effect at the next reload.
- Credits use unsigned WEIGHT_WIDTH arithmetic and never underflow, because only clients with credit>0 are granted.
- enable=0 while BUSY: the current grant completes normally; no new grant afterwards.
- Reset asserted mid-transaction: immediate clear to reset values; the transaction is abandoned.

Decomposition:
- Package mem_arb_pkg:
  - sched_state_t enum {IDLE, BUSY}
  - constants MODE_FIXED=1'b0, MODE_WRR=1'b1
  - function onehot_to_id
- Sub-module mem_arb_rr_pick (combinational): inputs eligible vector and start pointer; outputs one-hot winner and found flag. The same instance serves fixed priority with pointer=0 and eligible=req.

Test Plan:
- Reset: rst=0 with req=3'b111 → gnt=0, gnt_valid=0, gnt_id=0. rst released, enable=1, mode=0 → gnt=3'b001 one cycle later.
- Latency: req=3'b001 in IDLE at cycle t → gnt=3'b001 at t+1; m_ack at t+4 → gnt=0 at t+5; with req still set, next gnt at t+6.
- Fixed priority: mode=0, req=3'b110 → gnt_id=1; then req=3'b100 → gnt_id=2.
- WRR: mode=1, weights {2:2, 1:1, 0:3}, req=3'b111 held, each grant acked after 2 cycles → gnt_id sequence 0,0,0,1,2,2,0,0,0,1,2,2.
- Weight 0 and reload: weights all 0, req=3'b101 → sequence 0,2,0,2 (effective weight 1, reload each round).
- Disable and reset: enable→0 during BUSY → current grant completes, no further grant. Separately, rst=0 during BUSY → gnt=0 asynchronously, state IDLE, credits cleared.
